// File: rtl/mips16_mux_pkg.sv
// Shared helpers for select-encoded MIPS16 datapath muxes.
package mips16_mux_pkg;

    // Width of a channel index for n channels, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first requester at or after ptr, wrapping
// circularly. Works for any channel count, not only powers of two.
module rr_pick #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    localparam logic [SEL_W:0] N_V = (SEL_W + 1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [SEL_W-1:0] off;
    logic           found;
    logic [SEL_W:0] sum;

    // Rotate a doubled request vector so ptr lands at bit 0, priority-encode
    // the lowest set bit, then fold the offset back into the 0..N-1 range.
    always_comb begin
        dbl       = {req, req};
        rot       = N'(dbl >> ptr);
        gnt_valid = |req;
        off       = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                off   = SEL_W'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_V) begin
            sum = sum - N_V;
        end
        gnt_idx = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel round-robin arbitrating mux with a registered output beat and
// valid/ready handshakes on every port. All flops live here.
module rr_mux_reg
    import mips16_mux_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int N     = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    input  logic [WIDTH-1:0] in_data [N],
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    logic [SEL_W-1:0] ptr;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Accept a new beat when the output slot is empty or draining this cycle;
    // nothing is accepted while reset is asserted.
    always_comb begin
        can_load = !out_valid || out_ready;
        xfer     = rst_n && can_load && gnt_valid;
        in_ready = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                in_ready[i] = xfer;
                sel_data    = in_data[i];
            end
        end
    end

    // Output register and round-robin pointer: load on transfer (replacing a
    // draining beat in the same edge), clear valid on a drain without reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= gnt_idx;
            ptr       <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/rr_mux_reg.md
# rr_mux_reg

Parametrised N-channel, WIDTH-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes on every port. It is the sequential successor to the 1-bit 2:1 select mux. It replaces hard-wired select lines where several MIPS16 datapath sources (e.g. fetch, load/store, debug) compete for one shared sink. Selection is round-robin fair, the output holds while the sink stalls, and the block sustains one beat per cycle.

## Interface
- WIDTH, 16, data bits per channel (>=1)
- N, 4, number of input channels (>=1, any value, not only powers of two)
- SEL_W, derived = max(1, $clog2(N)), width of channel index; not overridable
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  N  per-channel request
- in_data  input  N x WIDTH  per-channel payload, unpacked array [N]
- in_ready  output  N  per-channel accept, at most one bit high per cycle
- out_valid  output  1  registered beat present
- out_data  output  WIDTH  registered payload
- out_sel  output  SEL_W  index of channel that produced current beat
- out_ready  input  1  sink accepts beat

## Operation
- State: output register (out_valid, out_data, out_sel) and round-robin pointer ptr (SEL_W bits, range 0..N-1).
- Grant: lowest index g in the circular order ptr, ptr+1, …, N-1, 0, …, ptr-1 with in_valid[g]=1. No grant if all in_valid=0.
- can_load = !out_valid || out_ready.
- in_ready[i] = can_load && grant valid && (g == i). Combinational; depends on in_valid and out_ready.
- Transfer on channel i when in_valid[i] && in_ready[i]. On the next edge: out_data<=in_data[i], out_sel<=i, out_valid<=1, ptr<=(i==N-1)?0:i+1.
- If out_valid && out_ready and no input transfer occurs: out_valid<=0. out_data and out_sel keep their last value.
- Simultaneous drain and load (out_valid && out_ready && transfer): new beat replaces old in the same edge, and out_valid stays 1.
- Stall (out_valid && !out_ready): all in_ready=0, and ptr, out_data and out_sel hold.
- ptr advances only on a transfer, never on idle cycles.
- N=1: ptr constant 0, block degenerates to a one-entry pipeline register.

## Timing
- Reset (rst_n=0, async): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready=0 while in reset.
- Reset mid-operation discards any held beat. The first grant after release starts at channel 0.
- Latency: input transfer at edge k makes out_valid=1 with that data from edge k until consumed.
- Throughput: one beat per cycle when out_ready is held 1.
- Handshake rules: in_valid must not depend on in_ready. Once asserted, a source holds in_valid and in_data stable until it transfers. The block holds out_valid/out_data/out_sel stable until out_ready.
- Fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0 in consecutive cycles. A waiting channel is served within N transfers.
- Combinational path out_ready -> in_ready is permitted. There is no path in_data -> out_data without a register.

## Structure
- Shared package mips16_mux_pkg: function sel_width(n) returning max(1,$clog2(n)), used here and by future select-encoded blocks. No typedefs are needed beyond it.
- One sub-module: rr_pick (combinational). Inputs are req[N] and ptr. Outputs are gnt_valid and gnt_idx. Implement it as a double-width request vector rotated by ptr, with a priority encoder and a modulo-N fold-back. rr_mux_reg owns all flops.
- Target 150–250 lines of RTL total.

## Test plan
- Reset: assert rst_n=0 mid-beat with out_valid=1, out_data=16'hBEEF. Required: out_valid, out_data and out_sel go to 0 immediately. After release with in_valid=4'b1111, the first grant is channel 0.
- Round-robin: N=4, all valid, out_ready=1, in_data[i]=16'h100+i. Required: out_data sequence 0x100,0x101,0x102,0x103,0x100 on consecutive cycles, and out_sel matches.
- Stall: out_valid=1 with 0x0102, out_ready=0 for 3 cycles, in_valid=4'b1011. Required: in_ready=0, and out_data and ptr hold. When out_ready=1, channel 3 is granted in that same cycle.
- Sparse/wrap: ptr=3, only in_valid[1]=1. Required: grant 1 and ptr becomes 2. Next, with only in_valid[3] valid, grant 3 and ptr wraps to 0.
- Non-power-of-two: N=3, all valid. Required: out_sel cycles 0,1,2,0, and ptr never reaches 3.
- Back-to-back with bubbles: in_valid pattern 1,0,1 on channel 2 only, out_ready=1. Required: out_valid pattern 1,0,1 one cycle later, and in_ready[0]=in_ready[1]=in_ready[3]=0 throughout.
